// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, with a one-entry registered output.
// Latency 1 cycle; in_ready drops when the held word is not being taken (out_valid && !out_ready).
module mux_nto1_stream #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] g;
  logic            grant_ok;
  logic            space;
  logic            load;
  logic [W-1:0]    g_data;

  assign space = !out_valid || out_ready;
  assign load  = grant_ok && space && !rst;

  // Round-robin scans downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    g        = '0;
    grant_ok = 1'b0;
    idx      = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          g        = SELW'(i);
          grant_ok = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[idx]) begin
          g        = SELW'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) g_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && (g == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_ch    <= g;
      if (MODE == 1) rr_ptr <= (g == SELW'(N - 1)) ? '0 : g + SELW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_stall_no_ready : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |-> (in_ready == '0));

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: three builds (N4 fixed, N4 round-robin, N5 fixed) against one spec-level model.
module tb_mux_nto1_stream;

  logic clk;
  logic rst;
  logic [2:0]  sel  [3];
  logic [4:0]  v    [3];
  logic [39:0] dat  [3];
  logic        ordy [3];

  logic [3:0] rdy0, rdy1;
  logic [4:0] rdy5;
  logic       ov0, ov1, ov5;
  logic [7:0] od0, od1, od5;
  logic [1:0] och0, och1;
  logic [2:0] och5;

  logic [4:0] rdy_a [3];
  logic       ov_a  [3];
  logic [7:0] od_a  [3];
  logic [2:0] och_a [3];

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // Model state: the output register contents and the round-robin pointer.
  int mv [3];
  int md [3];
  int mch [3];
  int mptr [3];
  int mode_of [3] = '{0, 1, 0};
  int n_of    [3] = '{4, 4, 5};

  mux_nto1_stream #(.N(4), .W(8), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .sel(sel[0][1:0]), .in_valid(v[0][3:0]), .in_data(dat[0][31:0]),
    .in_ready(rdy0), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .out_ch(och0));

  mux_nto1_stream #(.N(4), .W(8), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .sel(sel[1][1:0]), .in_valid(v[1][3:0]), .in_data(dat[1][31:0]),
    .in_ready(rdy1), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .out_ch(och1));

  mux_nto1_stream #(.N(5), .W(8), .MODE(0)) d5 (
    .clk(clk), .rst(rst), .sel(sel[2]), .in_valid(v[2]), .in_data(dat[2]),
    .in_ready(rdy5), .out_valid(ov5), .out_ready(ordy[2]), .out_data(od5), .out_ch(och5));

  always_comb begin
    rdy_a[0] = {1'b0, rdy0};  ov_a[0] = ov0; od_a[0] = od0; och_a[0] = {1'b0, och0};
    rdy_a[1] = {1'b0, rdy1};  ov_a[1] = ov1; od_a[1] = od1; och_a[1] = {1'b0, och1};
    rdy_a[2] = rdy5;          ov_a[2] = ov5; od_a[2] = od5; och_a[2] = och5;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Granted channel by the arbitration rules, or -1 when nothing can be granted.
  function automatic int grant(int mode, int n, int ptr, int s, logic [4:0] vv);
    if (mode == 0) return (s < n && vv[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (vv[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int gg;
      gg = grant(mode_of[d], n_of[d], mptr[d], int'(sel[d]), v[d]);
      if (rst) begin
        mv[d] <= 0; md[d] <= 0; mch[d] <= 0; mptr[d] <= 0;
        armed <= 1;
      end else if ((mv[d] == 0 || ordy[d]) && gg >= 0) begin
        mv[d]  <= 1;
        md[d]  <= int'(dat[d][gg*8 +: 8]);
        mch[d] <= gg;
        if (mode_of[d] == 1) mptr[d] <= (gg + 1) % n_of[d];
      end else if (ordy[d]) begin
        mv[d] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        int gg;
        int er;
        gg = grant(mode_of[d], n_of[d], mptr[d], int'(sel[d]), v[d]);
        er = (!rst && (mv[d] == 0 || ordy[d]) && gg >= 0) ? (1 << gg) : 0;
        chk($sformatf("dut%0d in_ready", d), int'(rdy_a[d]), er);
        chk($sformatf("dut%0d out_valid", d), int'(ov_a[d]), mv[d]);
        chk($sformatf("dut%0d out_data", d), int'(od_a[d]), md[d]);
        chk($sformatf("dut%0d out_ch", d), int'(och_a[d]), mch[d]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr [4];
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sel[d] = '0; v[d] = '0; dat[d] = '0; ordy[d] = 1'b0;
    end
    cyc(); cyc();
    chk("reset out_valid", int'(ov0), 0);
    chk("reset out_data", int'(od0), 0);
    chk("reset in_ready", int'(rdy0), 0);

    // Fixed select walks each channel.
    rst = 1'b0;
    v[0] = 5'h0F; dat[0] = 40'h0008040201; ordy[0] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel[0] = 3'(s);
      cyc();
      chk($sformatf("sel%0d data", s), int'(od0), 1 << s);
      chk($sformatf("sel%0d ch", s), int'(och0), s);
      chk($sformatf("sel%0d model", s), md[0], 1 << s);
    end

    // Reset while streaming.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst out_valid", int'(ov0), 0);
      chk("rst out_data", int'(od0), 0);
      chk("rst out_ch", int'(och0), 0);
      chk("rst in_ready", int'(rdy0), 0);
    end
    rst = 1'b0;
    #1 chk("post-rst in_ready", int'(rdy0), 4'b1000);
    cyc();
    chk("post-rst data", int'(od0), 8'h08);
    chk("post-rst ch", int'(och0), 3);

    // Backpressure holds A5, then reload with no bubble.
    sel[0] = 3'd0; dat[0][7:0] = 8'hA5;
    cyc();
    chk("bp load", int'(od0), 8'hA5);
    ordy[0] = 1'b0; dat[0][7:0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp hold data", int'(od0), 8'hA5);
      chk("bp hold valid", int'(ov0), 1);
      chk("bp in_ready", int'(rdy0), 0);
    end
    ordy[0] = 1'b1;
    #1 chk("bp release in_ready", int'(rdy0), 4'b0001);
    cyc();
    chk("bp reload data", int'(od0), 8'h5A);
    chk("bp reload valid", int'(ov0), 1);
    v[0] = '0;
    cyc();

    // Round-robin over all four, then alternating 1/3.
    v[1] = 5'h0F; dat[1] = 40'h0040302010; ordy[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("rr%0d ch", i), int'(och1), i % 4);
      chk($sformatf("rr%0d data", i), int'(od1), 16 * (i % 4 + 1));
    end
    v[1] = 5'b01010;
    exp_rr = '{3, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rr1010_%0d ch", i), int'(och1), exp_rr[i]);
    end

    // Pointer wrap from 3.
    v[1] = 5'b00100;
    cyc();
    chk("wrap pre ch", int'(och1), 2);
    chk("wrap model ptr3", mptr[1], 3);
    v[1] = 5'b00001;
    cyc();
    chk("wrap grant0", int'(och1), 0);
    chk("wrap model ptr1", mptr[1], 1);
    v[1] = 5'b01001;
    cyc();
    chk("wrap grant3", int'(och1), 3);
    v[1] = '0;
    cyc();

    // Out-of-range select on the 5-channel build.
    sel[2] = 3'd5; v[2] = 5'h1F; dat[2] = 40'h5544332211; ordy[2] = 1'b1;
    #1 chk("sel5 in_ready", int'(rdy5), 0);
    cyc();
    chk("sel5 no load", int'(ov5), 0);
    sel[2] = 3'd4;
    cyc();
    chk("sel4 valid", int'(ov5), 1);
    chk("sel4 ch", int'(och5), 4);
    chk("sel4 data", int'(od5), 8'h55);
    sel[2] = 3'd7;
    cyc();
    chk("sel7 drained", int'(ov5), 0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int d = 0; d < 3; d++) begin
        v[d]    = 5'($urandom) & 5'((1 << n_of[d]) - 1);
        sel[d]  = (d == 2) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
        dat[d]  = {8'($urandom), 32'($urandom)};
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      v[d] = '0; ordy[d] = 1'b1;
    end
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
